net_route_sched: RTL
====================

# net_route_sched

Dispatch scheduler for the detailed-routing engine. Nets to be routed (e.g. net1230..net1240 of a placed design) are queued by net ID. The block hands each net to one of `NUM_WORKERS` parallel router workers using round-robin arbitration, collects completions, re-queues failed nets for rip-up-and-reroute, and signals when the whole batch is finished.

## Interface
- `NUM_WORKERS`, 4: number of router workers, 2..8.
- `NET_W`, 16: net ID width.
- `DEPTH`, 16: pending-net FIFO depth, power of two.
- `MAX_RETRY`, 3: reroute attempts per net after its first failure, ≤ 3 (2-bit retry field).

Ports:
- `clk` in 1: clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: new net offered.
- `in_ready` out 1: net accepted when `in_valid & in_ready`.
- `in_net` in `NET_W`: net ID.
- `start` in 1: pulse; IDLE→RUN.
- `flush` in 1: pulse; RUN→DRAIN (end of batch).
- `wk_idle` in `NUM_WORKERS`: worker can accept a job.
- `disp_valid` out 1: one-cycle job dispatch pulse.
- `disp_worker` out 3: target worker index.
- `disp_net` out `NET_W`: dispatched net ID.
- `cmp_valid` in 1: completion strobe.
- `cmp_worker` in 3: completing worker.
- `cmp_fail` in 1: route failed.
- `busy` out 1: state ≠ IDLE.
- `batch_done` out 1: one-cycle pulse at DRAIN→IDLE.
- `routed_cnt` out 16: successful routes, saturating.
- `fail_cnt` out 16: nets dropped as unroutable, saturating.
- `proto_err` out 1: sticky; completion from a worker with no job outstanding.

## Operation
- The FIFO entry is {retry[1:0], net}. Fresh nets enter with retry = 0.
- Per-worker registers: `own[i]` (job outstanding), `own_net[i]`, `own_retry[i]`.
- `in_ready = (state != DRAIN) & (fifo_count + outstanding < DEPTH)`. This guarantees that a requeue always fits.
- FSM:
  - IDLE: accept input, no dispatch. `start` → RUN.
  - RUN: accept input and dispatch. `flush` → DRAIN.
  - DRAIN: dispatch only. When FIFO is empty and no job is outstanding, go to IDLE and pulse `batch_done`.
  - `start` outside IDLE and `flush` outside RUN are ignored.
- Dispatch (RUN/DRAIN), at most one per cycle:
  - Eligible set is `wk_idle & ~own`.
  - If the FIFO is non-empty and the eligible set is non-empty, pick the first eligible worker at or after `rr_ptr` (wrap-around), pop the FIFO, set `own`, and store net and retry.
  - `rr_ptr` then moves to the granted index + 1, mod `NUM_WORKERS`.
- Completion (any state, including IDLE):
  - If `own[cmp_worker]` is 0, set `proto_err` and make no other change.
  - Otherwise clear `own`.
  - Success: increment `routed_cnt`.
  - Failure: handled per Configuration.
- Same-cycle events:
  - Completion, dispatch and push may coincide.
  - Write priority into the FIFO is requeue first, then `in_net` (both may be written in one cycle; the FIFO has two write ports).
  - A worker that completes in cycle t is not eligible for dispatch until t+1.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: `in_ready` = 1, `disp_valid` = 0, `disp_worker` = 0, `disp_net` = 0, `busy` = 0, `batch_done` = 0, `routed_cnt` = 0, `fail_cnt` = 0, `proto_err` = 0. Also state = IDLE, `rr_ptr` = 0, FIFO empty, `own` = 0.
- All outputs are registered.
- Dispatch latency:
  - Conditions true at edge t give `disp_valid` high during cycle t+1.
  - An entry pushed at edge t is dispatchable at edge t+1, so `disp_valid` is high in cycle t+2.
- A requeued net is dispatchable one cycle after its completion edge.
- `batch_done` is high in the cycle after the last completion that empties the batch.
- `rst` mid-batch discards all queued and outstanding jobs immediately. Workers are reset externally.

## Configuration
- `NET_ROUTE_SCHED_RETRY_EN` defined:
  - A failed job with retry < `MAX_RETRY` is requeued with retry + 1.
  - Otherwise it is dropped and `fail_cnt` increments.
- Undefined:
  - Every failure is dropped and `fail_cnt` increments.
  - No requeue path or retry storage is built; the retry field reads 0.

## Test plan
- Reset, push nets 1230..1233, `start`, `wk_idle` = 4'b1111 → dispatches to workers 0, 1, 2, 3 in consecutive cycles with nets in order; `busy` = 1.
- Round-robin: with `rr_ptr` = 2 and `wk_idle` = 4'b0011 → next grant is worker 0, then worker 1.
- Retry (macro on, `MAX_RETRY` = 3): net 1235 fails 4 times → redispatched 3 times, then `fail_cnt` = 1 and `routed_cnt` unchanged.
- Macro off: net 1235 fails once → `fail_cnt` = 1 and no redispatch.
- Backpressure: `DEPTH` = 16, 4 outstanding and 12 queued → `in_ready` = 0. A completion with fail + requeue leaves `in_ready` still 0. A success completion gives `in_ready` = 1 next cycle.
- `flush` with 2 jobs outstanding, both succeed → `batch_done` pulses once, 1 cycle after the second completion. A `cmp_valid` for an unowned worker → `proto_err` = 1 and it stays set until `rst`.

Source files
------------

// File: rtl/net_route_sched.sv
// ---------------------------------------------------------------------------
// net_route_sched
//
// Dispatch scheduler for the detailed-routing engine. Net IDs are queued in
// a pending FIFO, handed out one per cycle to NUM_WORKERS router workers by
// round-robin arbitration, and their completions are collected. Failed nets
// are either re-queued for rip-up-and-reroute or dropped as unroutable. A
// batch is opened with start, closed with flush, and reports batch_done once
// everything queued and outstanding has completed.
//
// Optional feature macro: NET_ROUTE_SCHED_RETRY_EN
//   defined   : a failed net with retry < MAX_RETRY is re-queued with retry+1,
//               otherwise it is dropped and fail_cnt increments.
//   undefined : every failure is dropped; no requeue path or retry storage.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready new net handshake, in_net is the net ID
//   start, flush      batch control pulses (IDLE->RUN, RUN->DRAIN)
//   wk_idle           per-worker "can accept a job"
//   disp_valid        one-cycle dispatch pulse with disp_worker / disp_net
//   cmp_valid         completion strobe from cmp_worker, cmp_fail = failed
//   busy              scheduler not idle
//   batch_done        one-cycle pulse when a drained batch returns to IDLE
//   routed_cnt        successful routes (saturating)
//   fail_cnt          nets dropped as unroutable (saturating)
//   proto_err         sticky: completion from a worker with no job outstanding
// ---------------------------------------------------------------------------
module net_route_sched #(
   parameter int NUM_WORKERS = 4,
   parameter int NET_W       = 16,
   parameter int DEPTH       = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NET_W-1:0]       in_net,
   input  logic                   start,
   input  logic                   flush,
   input  logic [NUM_WORKERS-1:0] wk_idle,
   output logic                   disp_valid,
   output logic [2:0]             disp_worker,
   output logic [NET_W-1:0]       disp_net,
   input  logic                   cmp_valid,
   input  logic [2:0]             cmp_worker,
   input  logic                   cmp_fail,
   output logic                   busy,
   output logic                   batch_done,
   output logic [15:0]            routed_cnt,
   output logic [15:0]            fail_cnt,
   output logic                   proto_err
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int WIW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

   if (NUM_WORKERS < 2 || NUM_WORKERS > 8 || MAX_RETRY > 3 || DEPTH < 2 ||
       (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
      $error("net_route_sched: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state, state_nxt;
   logic                   batch_done_nxt;
   logic                   in_ready_nxt;

   logic [NET_W-1:0]       fifo_net [DEPTH];
   logic [AW-1:0]          rd_ptr, wr_ptr, push_addr;
   logic [CW-1:0]          count, count_nxt;

   logic [NUM_WORKERS-1:0] own, own_nxt;
   logic [2:0]             rr_ptr;

`ifdef NET_ROUTE_SCHED_RETRY_EN
   logic [1:0]             fifo_retry [DEPTH];
   logic [NET_W-1:0]       own_net    [NUM_WORKERS];
   logic [1:0]             own_retry  [NUM_WORKERS];
`endif

   logic [7:0]             elig8;
   logic [2:0]             cand;
   logic                   grant_vld;
   logic [2:0]             grant_idx;
   logic [WIW-1:0]         gw, cw;
   logic                   pop, push, cmp_hit, req, drop, succ;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic int popcnt(input logic [NUM_WORKERS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < NUM_WORKERS; i++) n += int'(v[i]);
      return n;
   endfunction

   // A worker is eligible only when idle and not already holding a job; the
   // registered own[] keeps a worker that completes this cycle ineligible
   // until the next one.
   assign elig8 = 8'(wk_idle & ~own);

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 3'd0;
      cand      = 3'd0;
      for (int k = 0; k < NUM_WORKERS; k++) begin
         cand = 3'((int'(rr_ptr) + k) % NUM_WORKERS);
         if (!grant_vld && elig8[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign gw      = grant_idx[WIW-1:0];
   assign cw      = cmp_worker[WIW-1:0];
   assign pop     = grant_vld && (count != '0) && (state != IDLE);
   assign push    = in_valid && in_ready;
   assign cmp_hit = cmp_valid && (int'(cmp_worker) < NUM_WORKERS) && own[cw];

`ifdef NET_ROUTE_SCHED_RETRY_EN
   assign req = cmp_hit && cmp_fail && (int'(own_retry[cw]) < MAX_RETRY);
`else
   assign req = 1'b0;
`endif
   assign drop = cmp_hit && cmp_fail && !req;
   assign succ = cmp_hit && !cmp_fail;

   // Requeue takes the first write slot, the fresh net the one after it.
   assign push_addr = wr_ptr + AW'(req);
   assign count_nxt = count + CW'(req) + CW'(push) - CW'(pop);

   always_comb begin
      own_nxt = own;
      if (cmp_hit) own_nxt[cw] = 1'b0;
      if (pop)     own_nxt[gw] = 1'b1;
   end

   // Queued plus outstanding never exceeds DEPTH, so a requeue always fits.
   assign in_ready_nxt = (state_nxt != DRAIN) &&
                         ((int'(count_nxt) + popcnt(own_nxt)) < DEPTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      batch_done_nxt = 1'b0;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (flush) state_nxt = DRAIN;
         DRAIN:   if (count_nxt == '0 && own_nxt == '0) begin
                     state_nxt      = IDLE;
                     batch_done_nxt = 1'b1;
                  end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own         <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         rr_ptr      <= 3'd0;
         in_ready    <= 1'b1;
         disp_valid  <= 1'b0;
         disp_worker <= 3'd0;
         disp_net    <= '0;
         busy        <= 1'b0;
         batch_done  <= 1'b0;
         routed_cnt  <= 16'd0;
         fail_cnt    <= 16'd0;
         proto_err   <= 1'b0;
      end else begin
         own        <= own_nxt;
         count      <= count_nxt;
         rd_ptr     <= rd_ptr + AW'(pop);
         wr_ptr     <= wr_ptr + AW'(req) + AW'(push);
         disp_valid <= pop;
         if (pop) begin
            rr_ptr      <= 3'((int'(grant_idx) + 1) % NUM_WORKERS);
            disp_worker <= grant_idx;
            disp_net    <= fifo_net[rd_ptr];
         end
         in_ready   <= in_ready_nxt;
         busy       <= (state_nxt != IDLE);
         batch_done <= batch_done_nxt;
         if (succ) routed_cnt <= sat_inc(routed_cnt);
         if (drop) fail_cnt   <= sat_inc(fail_cnt);
         if (cmp_valid && !cmp_hit) proto_err <= 1'b1;
      end
   end

   // Payload storage: not reset, qualified by the control state above.
   always_ff @(posedge clk) begin
      if (push) fifo_net[push_addr] <= in_net;
`ifdef NET_ROUTE_SCHED_RETRY_EN
      if (req) begin
         fifo_net[wr_ptr]   <= own_net[cw];
         fifo_retry[wr_ptr] <= own_retry[cw] + 2'd1;
      end
      if (push) fifo_retry[push_addr] <= 2'd0;
      if (pop) begin
         own_net[gw]   <= fifo_net[rd_ptr];
         own_retry[gw] <= fifo_retry[rd_ptr];
      end
`endif
   end

endmodule
